// File: rtl/sine_lut_scheduler.sv
// sine_lut_scheduler
//   Steps N_CH phase accumulators through one shared, synchronous, half-period
//   sine ROM. On each sample strobe every channel is read back-to-back, the
//   half-wave sign is applied, and all outputs update together so the phases
//   stay coherent.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   en           : sample strobe, starts a frame (ignored + overrun when busy)
//   lut_addr     : registered ROM address
//   lut_rd       : ROM read enable, high while lut_addr is valid
//   lut_data     : ROM magnitude, valid one cycle after lut_addr/lut_rd
//   cfg_wr       : write step/phase shadows of channel cfg_ch
//   cfg_ch       : channel index for cfg_wr
//   cfg_step     : new step (shadow)
//   cfg_phase    : new start position (shadow)
//   cfg_sync     : reload positions from phase shadows at next frame start
//   cfg_err      : 1-cycle pulse when a cfg_wr is rejected
//   out_wave     : packed signed samples, ch0 in the LSB slice
//   frame_valid  : 1-cycle pulse when out_wave updates
//   busy         : frame in progress
//   overrun      : sticky, en arrived while busy
module sine_lut_scheduler #(
  parameter int N_CH      = 3,
  parameter int LUT_DEPTH = 10000,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic [ADDR_W-1:0]             lut_addr,
  output logic                          lut_rd,
  input  logic [DATA_W-1:0]             lut_data,
  input  logic                          cfg_wr,
  input  logic [1:0]                    cfg_ch,
  input  logic [ADDR_W-1:0]             cfg_step,
  input  logic [ADDR_W:0]               cfg_phase,
  input  logic                          cfg_sync,
  output logic                          cfg_err,
  output logic [N_CH*(DATA_W+1)-1:0]    out_wave,
  output logic                          frame_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int POS_W = ADDR_W + 1;
  localparam int SMP_W = DATA_W + 1;
  localparam logic [POS_W-1:0] PERIOD   = POS_W'(2 * LUT_DEPTH);
  localparam logic [POS_W-1:0] HALF     = POS_W'(LUT_DEPTH);
  localparam logic [2:0]       N_CH_W   = 3'(N_CH);
  localparam logic [1:0]       LAST_CH  = 2'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, UPDATE} state_t;

  state_t                   state_reg;
  logic [1:0]               ch_reg;
  logic                     sync_pending_reg;

  logic [POS_W-1:0]         pos_reg          [N_CH];
  logic [ADDR_W-1:0]        step_reg         [N_CH];
  logic [POS_W-1:0]         phase_shadow_reg [N_CH];
  logic [ADDR_W-1:0]        step_shadow_reg  [N_CH];
  logic [POS_W-1:0]         phase_shadow_next[N_CH];
  logic [ADDR_W-1:0]        step_shadow_next [N_CH];
  logic signed [SMP_W-1:0]  staging_reg      [N_CH];
  logic [N_CH*SMP_W-1:0]    staging_flat;

  // Sign/channel tags travel alongside the ROM read so the capture cycle
  // knows what the returning magnitude belongs to.
  logic                     sign_issue_reg, sign_rom_reg;
  logic [1:0]               idx_issue_reg, idx_rom_reg;
  logic                     rd_rom_reg;

  logic                     cfg_ok;
  logic                     frame_start;
  logic                     sync_now;
  logic                     issue_valid;
  logic [1:0]               issue_ch;
  logic [POS_W-1:0]         pos_src;
  logic [ADDR_W-1:0]        step_src;
  logic [POS_W:0]           pos_sum;
  logic [POS_W-1:0]         pos_new;
  logic                     issue_neg;
  logic [ADDR_W-1:0]        issue_addr;
  logic [SMP_W-1:0]         mag_ext;
  logic signed [SMP_W-1:0]  sample;

  assign cfg_ok      = cfg_wr && ({1'b0, cfg_ch} < N_CH_W) && (cfg_phase < PERIOD);
  assign frame_start = en && (state_reg == IDLE);
  assign sync_now    = sync_pending_reg || cfg_sync;

  // Channel 0 is issued on the same edge that starts the frame, so it must
  // see this cycle's cfg write / sync request directly rather than waiting
  // for the shadow and live registers to catch up.
  always_comb begin
    issue_valid = 1'b0;
    issue_ch    = 2'd0;
    pos_src     = '0;
    step_src    = '0;
    if (frame_start) begin
      issue_valid = 1'b1;
      pos_src     = sync_now ? phase_shadow_next[0] : pos_reg[0];
      step_src    = step_shadow_next[0];
    end else if (state_reg == ISSUE && ch_reg != LAST_CH) begin
      issue_valid = 1'b1;
      issue_ch    = ch_reg + 2'd1;
      pos_src     = pos_reg[issue_ch];
      step_src    = step_reg[issue_ch];
    end
  end

  assign pos_sum    = {1'b0, pos_src} + (POS_W+1)'(step_src);
  assign pos_new    = (pos_sum >= {1'b0, PERIOD}) ? POS_W'(pos_sum - {1'b0, PERIOD})
                                                  : POS_W'(pos_sum);
  assign issue_neg  = (pos_src >= HALF);
  assign issue_addr = issue_neg ? ADDR_W'(pos_src - HALF) : ADDR_W'(pos_src);

  assign mag_ext = {1'b0, lut_data};
  assign sample  = sign_rom_reg ? -$signed(mag_ext) : $signed(mag_ext);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam logic [POS_W-1:0] RST_POS = POS_W'((gi * 2 * LUT_DEPTH) / N_CH);
      localparam logic [1:0]       CH_ID   = 2'(gi);

      assign step_shadow_next[gi]  = (cfg_ok && cfg_ch == CH_ID) ? cfg_step  : step_shadow_reg[gi];
      assign phase_shadow_next[gi] = (cfg_ok && cfg_ch == CH_ID) ? cfg_phase : phase_shadow_reg[gi];
      assign staging_flat[gi*SMP_W +: SMP_W] = staging_reg[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          step_shadow_reg[gi]  <= ADDR_W'(1);
          phase_shadow_reg[gi] <= RST_POS;
          step_reg[gi]         <= ADDR_W'(1);
          pos_reg[gi]          <= RST_POS;
          staging_reg[gi]      <= '0;
        end else begin
          step_shadow_reg[gi]  <= step_shadow_next[gi];
          phase_shadow_reg[gi] <= phase_shadow_next[gi];
          if (frame_start)
            step_reg[gi] <= step_shadow_next[gi];
          if (issue_valid && issue_ch == CH_ID)
            pos_reg[gi] <= pos_new;
          else if (frame_start && sync_now)
            pos_reg[gi] <= phase_shadow_next[gi];
          if (rd_rom_reg && idx_rom_reg == CH_ID)
            staging_reg[gi] <= sample;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      ch_reg           <= 2'd0;
      sync_pending_reg <= 1'b0;
      lut_addr         <= '0;
      lut_rd           <= 1'b0;
      cfg_err          <= 1'b0;
      out_wave         <= '0;
      frame_valid      <= 1'b0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      sign_issue_reg   <= 1'b0;
      sign_rom_reg     <= 1'b0;
      idx_issue_reg    <= 2'd0;
      idx_rom_reg      <= 2'd0;
      rd_rom_reg       <= 1'b0;
    end else begin
      frame_valid  <= 1'b0;
      cfg_err      <= cfg_wr && !cfg_ok;
      rd_rom_reg   <= lut_rd;
      sign_rom_reg <= sign_issue_reg;
      idx_rom_reg  <= idx_issue_reg;

      if (en && state_reg != IDLE)
        overrun <= 1'b1;

      if (frame_start)
        sync_pending_reg <= 1'b0;
      else if (cfg_sync)
        sync_pending_reg <= 1'b1;

      if (issue_valid) begin
        lut_addr       <= issue_addr;
        lut_rd         <= 1'b1;
        sign_issue_reg <= issue_neg;
        idx_issue_reg  <= issue_ch;
      end

      case (state_reg)
        IDLE: begin
          if (en) begin
            state_reg <= ISSUE;
            ch_reg    <= 2'd0;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (ch_reg == LAST_CH) begin
            state_reg <= DRAIN;
            lut_rd    <= 1'b0;
          end else begin
            ch_reg <= ch_reg + 2'd1;
          end
        end
        DRAIN: begin
          // last ROM word is captured on this edge
          state_reg <= UPDATE;
        end
        UPDATE: begin
          out_wave    <= staging_flat;
          frame_valid <= 1'b1;
          busy        <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_lut_scheduler.sv
// Testbench for sine_lut_scheduler: directed scenarios followed by randomized
// config/frame traffic, compared against a position/step model of the
// channels and a ROM whose entry i holds i[11:0].
module tb_sine_lut_scheduler;
  localparam int N_CH      = 3;
  localparam int LUT_DEPTH = 10000;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 12;
  localparam int SMP_W     = DATA_W + 1;

  logic                       clk = 1'b0;
  logic                       rst, en, cfg_wr, cfg_sync;
  logic [ADDR_W-1:0]          lut_addr, cfg_step;
  logic                       lut_rd, cfg_err, frame_valid, busy, overrun;
  logic [DATA_W-1:0]          lut_data = '0;
  logic [1:0]                 cfg_ch;
  logic [ADDR_W:0]            cfg_phase;
  logic [N_CH*SMP_W-1:0]      out_wave;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_pos[N_CH], m_step[N_CH], m_step_sh[N_CH], m_phase_sh[N_CH];
  int m_wave[N_CH], exp_addr[N_CH], exp_next[N_CH];
  bit m_sync, m_overrun;

  always #5 clk = ~clk;

  // synchronous ROM: lut[i] = i mod 4096
  always @(posedge clk) if (lut_rd) lut_data <= lut_addr[DATA_W-1:0];

  sine_lut_scheduler #(.N_CH(N_CH), .LUT_DEPTH(LUT_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .lut_addr(lut_addr), .lut_rd(lut_rd), .lut_data(lut_data),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_step(cfg_step), .cfg_phase(cfg_phase),
    .cfg_sync(cfg_sync), .cfg_err(cfg_err), .out_wave(out_wave),
    .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wave_ch(input int k);
    logic signed [SMP_W-1:0] s;
    s = out_wave[k*SMP_W +: SMP_W];
    return int'(s);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_step[k] = 1; m_step_sh[k] = 1;
      m_pos[k] = (k * 2 * LUT_DEPTH) / N_CH;
      m_phase_sh[k] = m_pos[k];
      m_wave[k] = 0;
    end
    m_sync = 0; m_overrun = 0;
  endfunction

  // returns 1 when the write is rejected
  function automatic bit model_cfg(input int ch, input int step, input int phase);
    if (ch >= N_CH || phase >= 2 * LUT_DEPTH) return 1'b1;
    m_step_sh[ch] = step;
    m_phase_sh[ch] = phase;
    return 1'b0;
  endfunction

  // one frame: commit shadows, read every channel, advance positions
  function automatic void model_frame();
    int p;
    for (int k = 0; k < N_CH; k++) begin
      m_step[k] = m_step_sh[k];
      if (m_sync) m_pos[k] = m_phase_sh[k];
    end
    m_sync = 0;
    for (int k = 0; k < N_CH; k++) begin
      p = m_pos[k];
      if (p < LUT_DEPTH) begin
        exp_addr[k] = p;
        exp_next[k] = p % 4096;
      end else begin
        exp_addr[k] = p - LUT_DEPTH;
        exp_next[k] = -((p - LUT_DEPTH) % 4096);
      end
      m_pos[k] = (p + m_step[k]) % (2 * LUT_DEPTH);
    end
  endfunction

  task automatic do_reset();
    rst = 1; en = 0; cfg_wr = 0; cfg_sync = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check("rst_out_wave", out_wave, 0);
    check("rst_busy", busy, 0);
    check("rst_lut_rd", lut_rd, 0);
    check("rst_lut_addr", lut_addr, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cfg_err", cfg_err, 0);
  endtask

  task automatic cfg_only(input bit wr, input int ch, input int step, input int phase, input bit sync);
    bit bad;
    bad = wr ? model_cfg(ch, step, phase) : 1'b0;
    if (sync) m_sync = 1;
    cfg_wr = wr; cfg_ch = 2'(ch); cfg_step = ADDR_W'(step); cfg_phase = (ADDR_W+1)'(phase); cfg_sync = sync;
    @(posedge clk); #1;
    cfg_wr = 0; cfg_sync = 0;
    $display("cfg wr=%0d ch=%0d step=%0d phase=%0d sync=%0d -> cfg_err=%0d", wr, ch, step, phase, sync, cfg_err);
    check("cfg_err", cfg_err, wr && bad);
    @(posedge clk); #1;
    check("cfg_err_pulse", cfg_err, 0);
  endtask

  // Runs one frame with optional same-cycle cfg write / sync; extra_k > 0
  // pulses a second en so that it is sampled at edge E(extra_k).
  task automatic frame(input bit wr, input int wch, input int wstep, input int wphase,
                       input bit sync, input int extra_k, input bit chk_bus);
    bit bad;
    int fv_cnt;
    bad = wr ? model_cfg(wch, wstep, wphase) : 1'b0;
    if (sync) m_sync = 1;
    model_frame();
    cfg_wr = wr; cfg_ch = 2'(wch); cfg_step = ADDR_W'(wstep); cfg_phase = (ADDR_W+1)'(wphase);
    cfg_sync = sync; en = 1;
    @(posedge clk); #1;
    en = 0; cfg_wr = 0; cfg_sync = 0;
    check("cfg_err_frame", cfg_err, wr && bad);
    fv_cnt = 0;
    for (int k = 0; k <= N_CH + 2; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      en = (k + 1 == extra_k);
      if (frame_valid === 1'b1) fv_cnt++;
      if (k < N_CH + 2) check("busy", busy, 1);
      if (chk_bus) begin
        if (k < N_CH) begin
          check("lut_rd_hi", lut_rd, 1);
          check("lut_addr", lut_addr, exp_addr[k]);
        end else begin
          check("lut_rd_lo", lut_rd, 0);
        end
      end
    end
    en = 0;
    check("frame_valid", frame_valid, 1);
    check("frame_valid_once", fv_cnt, 1);
    check("busy_done", busy, 0);
    for (int k = 0; k < N_CH; k++) begin
      m_wave[k] = exp_next[k];
      check($sformatf("wave_ch%0d", k), wave_ch(k), m_wave[k]);
    end
    if (extra_k > 0) m_overrun = 1;
    check("overrun", overrun, m_overrun);
    $display("frame: ch0=%0d ch1=%0d ch2=%0d overrun=%0d", wave_ch(0), wave_ch(1), wave_ch(2), overrun);
    if (extra_k > 0) begin
      fv_cnt = 0;
      for (int k = 0; k < N_CH + 4; k++) begin
        @(posedge clk); #1;
        if (frame_valid !== 1'b0) fv_cnt++;
      end
      check("no_second_frame", fv_cnt, 0);
      check("overrun_held", overrun, 1);
    end
  endtask

  initial begin
    int wch, wstep, wphase;
    bit wr, sync;
    rst = 1; en = 0; cfg_wr = 0; cfg_sync = 0; cfg_ch = 0; cfg_step = 0; cfg_phase = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // post-reset frame with ROM bus checks
    frame(0, 0, 0, 0, 0, 0, 1);
    check("first_ch0", wave_ch(0), 0);
    check("first_ch1", wave_ch(1), 2570);
    check("first_ch2", wave_ch(2), -3333);

    // reprogram ch0, sync, then wrap across the full period
    cfg_only(1, 0, 7, 19998, 0);
    cfg_only(0, 0, 0, 0, 1);
    frame(0, 0, 0, 0, 0, 0, 1);
    check("sync_ch0", wave_ch(0), -1806);
    frame(0, 0, 0, 0, 0, 0, 0);
    check("wrap_ch0", wave_ch(0), 5);
    frame(0, 0, 0, 0, 0, 0, 0);
    check("next_ch0", wave_ch(0), 12);

    // en two cycles into the frame: ignored, overrun sticky until reset
    frame(0, 0, 0, 0, 0, 2, 1);
    frame(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // rejected writes leave shadows untouched
    cfg_only(1, 0, 5, 20000, 0);
    cfg_only(1, 3, 5, 100, 0);
    frame(0, 0, 0, 0, 0, 0, 1);

    // reset during the second ISSUE cycle
    en = 1;
    @(posedge clk); #1;
    en = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check("abort_busy", busy, 0);
    check("abort_lut_rd", lut_rd, 0);
    check("abort_out_wave", out_wave, 0);
    check("abort_frame_valid", frame_valid, 0);
    begin
      int fv_cnt;
      fv_cnt = 0;
      for (int k = 0; k < N_CH + 4; k++) begin
        @(posedge clk); #1;
        if (frame_valid !== 1'b0) fv_cnt++;
      end
      check("abort_no_frame", fv_cnt, 0);
    end
    frame(0, 0, 0, 0, 0, 0, 1);
    check("after_abort_ch0", wave_ch(0), 0);
    check("after_abort_ch1", wave_ch(1), 2570);
    check("after_abort_ch2", wave_ch(2), -3333);

    // randomized config / frame traffic
    for (int it = 0; it < 30; it++) begin
      wr     = 1'($urandom_range(0, 1));
      wch    = $urandom_range(0, 3);
      wstep  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 400);
      wphase = ($urandom_range(0, 9) == 0) ? 20000 + $urandom_range(0, 100) : $urandom_range(0, 19999);
      sync   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        frame(wr, wch, wstep, wphase, sync, 0, 1);
      end else begin
        cfg_only(wr, wch, wstep, wphase, sync);
        frame(0, 0, 0, 0, 0, 0, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
